permutation_sequencer: RTL and testbench
========================================

// Module: permutation_sequencer
// PURPOSE
//  Parametrised FSM sequencing an iterated permutation datapath over a run-time round count (1..MAX_ROUNDS).
//  Per round: a LOAD phase, then a RES phase.
//  Adds to the fixed-round controller: latched round count, round index for round-constant lookup,
//  and a DONE state that holds the result under an outValid/outReady handshake.
//  Sits between the top-level start/ready interface and the permutation datapath register/mux controls.
// PARAMETERS
//  MAX_ROUNDS  24  maximum rounds per call; numRounds above this saturates to MAX_ROUNDS
//  RW          5   round-count/index width; must satisfy 2**RW > MAX_ROUNDS
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous, active-low reset
//  start      in   1    request; sampled only in IDLE
//  numRounds  in   RW   rounds for this call; latched in the start cycle
//  outReady   in   1    downstream accepts the result
//  abort      in   1    cancel current call (only with PERM_ABORT_EN)
//  ready      out  1    IDLE; new start accepted
//  busy       out  1    INIT/LOAD/RES
//  cntClr     out  1    clear round counter
//  cntEn      out  1    increment round counter
//  putInput   out  1    datapath mux selects external input
//  ldReg      out  1    load datapath state register
//  selRes     out  1    datapath mux selects round result (0 = stage-1 value)
//  roundIdx   out  RW   current round number 0..N-1; round-constant address
//  lastRound  out  1    roundIdx == N-1 during LOAD/RES
//  outValid   out  1    DONE; datapath register holds the result
// BEHAVIOUR
//  - States: IDLE, INIT, LOAD, RES, DONE. Registered state; all outputs are Moore, decoded from state and counter only.
//  - Reset (rst=0, async): state=IDLE, counter=0, latched N=0.
//    Outputs during and after reset: ready=1, every other output 0, roundIdx=0.
//  - IDLE: ready=1.
//    * start=1: N <= min(numRounds, MAX_ROUNDS); go to INIT.
//    * Otherwise stay in IDLE.
//  - INIT: cntClr=1, putInput=1, ldReg=1 (load input).
//    * N==0: go to DONE (pass-through, zero rounds).
//    * Otherwise go to LOAD.
//  - LOAD: ldReg=1, selRes=0; go to RES.
//  - RES: ldReg=1, selRes=1, cntEn=1.
//    * Counter carry (roundIdx==N-1): go to DONE.
//    * Otherwise go to LOAD.
//  - DONE: outValid=1; ldReg=0, so the result is held stable.
//    * outReady=1: go to IDLE.
//    * Otherwise stay in DONE (backpressure, no timeout).
//  - Latency: start sampled at edge k -> INIT at k+1 -> DONE at k+2+2N.
//    Earliest next start accepted at the edge after the outReady handshake.
//  - start outside IDLE is ignored; numRounds changes after the start cycle have no effect.
//  - Counter: RW bits, cleared by cntClr, +1 on cntEn.
//    Carry is combinational when count==N-1; it never wraps inside a call.
//  - An async reset mid-call abandons the call; no outValid is produced for it.
// CONFIGURATION
//  PERM_ABORT_EN defined:
//    * abort port exists.
//    * abort=1 in INIT/LOAD/RES: next state IDLE, counter cleared; it overrides counter carry.
//    * abort in IDLE/DONE is ignored. No outValid for an aborted call.
//  PERM_ABORT_EN undefined: abort port absent; the FSM behaves as if abort=0.
// STRUCTURE
//  Shared package perm_pkg:
//    * state encoding localparams (IDLE/INIT/LOAD/RES/DONE, 3 bits).
//    * control-vector field order {ready,busy,cntClr,cntEn,putInput,ldReg,selRes,outValid}.
//    * MAX_ROUNDS default.
//  Sub-module round_counter #(RW): inputs clr, en, limit[RW-1:0]; outputs count[RW-1:0], co.
//  Top module holds the FSM, the N latch and the output decode.
// TESTING
//  1 N=3, outReady=1: INIT, then LOAD,RES x3 with roundIdx 0,1,2; lastRound only at idx 2;
//    outValid pulses 1 cycle at k+8; ready returns next cycle.
//  2 numRounds=0: INIT (putInput=1, ldReg=1) -> DONE; outValid at k+2; no cntEn pulse.
//  3 numRounds=31, MAX_ROUNDS=24: exactly 24 RES cycles; final roundIdx=23.
//  4 N=2, outReady=0 for 5 cycles in DONE: outValid held, ldReg=0, start ignored;
//    outReady=1 -> IDLE next edge.
//  5 rst low during RES of round 1: outputs immediately ready=1, others 0;
//    after release, a new N=1 call completes normally.
//  6 PERM_ABORT_EN, N=4, abort in RES of round 2 coinciding with no carry:
//    IDLE next cycle; outValid never asserted.

Source files
------------

// File: rtl/permutation_sequencer_pkg.sv
// Shared types for the permutation sequencer: state encoding, control-vector layout,
// default round limit and the round-count saturation helper.
package permutation_sequencer_pkg;

  localparam int MAX_ROUNDS_DEF = 24;
  localparam int STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_LOAD = 3'd2,
    S_RES  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Field order of the decoded control vector, MSB first.
  typedef struct packed {
    logic ready;
    logic busy;
    logic cnt_clr;
    logic cnt_en;
    logic put_input;
    logic ld_reg;
    logic sel_res;
    logic out_valid;
  } ctrl_t;

  function automatic int sat_rounds(input int req, input int max_rounds);
    return (req > max_rounds) ? max_rounds : req;
  endfunction

endpackage

// File: rtl/permutation_sequencer_if.sv
// Handshake and datapath-control bundle between the permutation sequencer and its
// surroundings. The abort line exists only when PERM_ABORT_EN is defined.
interface permutation_sequencer_if #(
  parameter int RW = 5
);
  logic          start;
  logic [RW-1:0] numRounds;
  logic          outReady;
`ifdef PERM_ABORT_EN
  logic          abort;
`endif
  logic          ready;
  logic          busy;
  logic          cntClr;
  logic          cntEn;
  logic          putInput;
  logic          ldReg;
  logic          selRes;
  logic [RW-1:0] roundIdx;
  logic          lastRound;
  logic          outValid;

  modport master (
    output start, numRounds, outReady,
`ifdef PERM_ABORT_EN
    output abort,
`endif
    input  ready, busy, cntClr, cntEn, putInput, ldReg, selRes,
    input  roundIdx, lastRound, outValid
  );

  modport slave (
    input  start, numRounds, outReady,
`ifdef PERM_ABORT_EN
    input  abort,
`endif
    output ready, busy, cntClr, cntEn, putInput, ldReg, selRes,
    output roundIdx, lastRound, outValid
  );

endinterface

// File: rtl/permutation_sequencer_round_counter.sv
// Round index counter: clear has priority over increment; carry flags the last round
// of the call (count == limit-1).
module permutation_sequencer_round_counter #(
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [RW-1:0] limit_i,
  output logic [RW-1:0] count_o,
  output logic          co_o
);

  logic [RW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
  assign co_o    = (count_q == (limit_i - 1'b1));

endmodule

// File: rtl/permutation_sequencer.sv
// Moore FSM sequencing an iterated permutation datapath over a run-time round count.
// Optional feature: define PERM_ABORT_EN to add a mid-call abort input.
module permutation_sequencer
  import permutation_sequencer_pkg::*;
#(
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEF,
  parameter int RW         = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  permutation_sequencer_if.slave      seq
);

  state_e        state_q, state_d;
  logic [RW-1:0] n_q, n_d;
  ctrl_t         ctrl;
  logic          abort_w;
  logic          cnt_clr_w;
  logic [RW-1:0] count;
  logic          co;

`ifdef PERM_ABORT_EN
  assign abort_w = seq.abort;
`else
  assign abort_w = 1'b0;
`endif

  // Abort only matters while a call is in flight; it also empties the counter.
  assign cnt_clr_w = ctrl.cnt_clr | (abort_w & ctrl.busy);

  permutation_sequencer_round_counter #(.RW(RW)) u_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (cnt_clr_w),
    .en_i    (ctrl.cnt_en),
    .limit_i (n_q),
    .count_o (count),
    .co_o    (co)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      S_IDLE: begin
        if (seq.start) begin
          n_d     = RW'(sat_rounds(int'(seq.numRounds), MAX_ROUNDS));
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        if (abort_w)         state_d = S_IDLE;
        else if (n_q == '0)  state_d = S_DONE;
        else                 state_d = S_LOAD;
      end
      S_LOAD: begin
        if (abort_w) state_d = S_IDLE;
        else         state_d = S_RES;
      end
      S_RES: begin
        if (abort_w) state_d = S_IDLE;
        else if (co) state_d = S_DONE;
        else         state_d = S_LOAD;
      end
      S_DONE: begin
        if (seq.outReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_IDLE: ctrl.ready = 1'b1;
      S_INIT: begin
        ctrl.busy      = 1'b1;
        ctrl.cnt_clr   = 1'b1;
        ctrl.put_input = 1'b1;
        ctrl.ld_reg    = 1'b1;
      end
      S_LOAD: begin
        ctrl.busy   = 1'b1;
        ctrl.ld_reg = 1'b1;
      end
      S_RES: begin
        ctrl.busy    = 1'b1;
        ctrl.ld_reg  = 1'b1;
        ctrl.sel_res = 1'b1;
        ctrl.cnt_en  = 1'b1;
      end
      S_DONE:  ctrl.out_valid = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign seq.ready     = ctrl.ready;
  assign seq.busy      = ctrl.busy;
  assign seq.cntClr    = ctrl.cnt_clr;
  assign seq.cntEn     = ctrl.cnt_en;
  assign seq.putInput  = ctrl.put_input;
  assign seq.ldReg     = ctrl.ld_reg;
  assign seq.selRes    = ctrl.sel_res;
  assign seq.outValid  = ctrl.out_valid;
  assign seq.roundIdx  = count;
  assign seq.lastRound = ((state_q == S_LOAD) || (state_q == S_RES)) && co;

endmodule

// File: tb/tb_permutation_sequencer.sv
// Directed testbench for permutation_sequencer with hand-computed expectations.
module tb_permutation_sequencer;

  localparam int RW = 5;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_i = ~clk_i;

  permutation_sequencer_if #(.RW(RW)) seq ();

  permutation_sequencer #(.MAX_ROUNDS(24), .RW(RW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .seq    (seq)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_call(input int n);
    seq.start     = 1'b1;
    seq.numRounds = RW'(n);
    step();
    seq.start     = 1'b0;
  endtask

  // Steps until outValid; cycles counts edges after the INIT edge.
  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (!seq.outValid && cycles < limit) begin
      step();
      cycles++;
    end
  endtask

  int cyc;
  int res_cnt;
  int last_idx;
  int seen_valid;

  initial begin
    seq.start     = 1'b0;
    seq.numRounds = '0;
    seq.outReady  = 1'b0;
`ifdef PERM_ABORT_EN
    seq.abort     = 1'b0;
`endif
    #12;
    check("rst_ready",    seq.ready,    1);
    check("rst_busy",     seq.busy,     0);
    check("rst_ldReg",    seq.ldReg,    0);
    check("rst_outValid", seq.outValid, 0);
    check("rst_roundIdx", seq.roundIdx, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    check("idle_ready", seq.ready, 1);

    // N=3 with downstream always ready
    seq.outReady = 1'b1;
    start_call(3);
    check("t1_init_cntClr",   seq.cntClr,   1);
    check("t1_init_putInput", seq.putInput, 1);
    check("t1_init_ldReg",    seq.ldReg,    1);
    check("t1_init_ready",    seq.ready,    0);
    for (int r = 0; r < 3; r++) begin
      step();
      check("t1_load_selRes", seq.selRes,    0);
      check("t1_load_ldReg",  seq.ldReg,     1);
      check("t1_load_idx",    seq.roundIdx,  r);
      check("t1_load_last",   seq.lastRound, (r == 2) ? 1 : 0);
      step();
      check("t1_res_selRes",  seq.selRes,    1);
      check("t1_res_cntEn",   seq.cntEn,     1);
      check("t1_res_idx",     seq.roundIdx,  r);
      check("t1_res_last",    seq.lastRound, (r == 2) ? 1 : 0);
    end
    step();
    check("t1_done_valid", seq.outValid, 1);
    check("t1_done_ldReg", seq.ldReg,    0);
    step();
    check("t1_idle_ready", seq.ready,    1);
    check("t1_idle_valid", seq.outValid, 0);

    // Zero rounds: pass-through
    start_call(0);
    check("t2_init_putInput", seq.putInput, 1);
    check("t2_init_ldReg",    seq.ldReg,    1);
    step();
    check("t2_done_valid", seq.outValid, 1);
    check("t2_done_cntEn", seq.cntEn,    0);
    step();
    check("t2_idle_ready", seq.ready, 1);

    // Saturation: 31 requested, 24 executed
    start_call(31);
    res_cnt  = 0;
    last_idx = -1;
    cyc      = 0;
    while (!seq.outValid && cyc < 200) begin
      if (seq.cntEn) begin
        res_cnt++;
        last_idx = int'(seq.roundIdx);
      end
      step();
      cyc++;
    end
    check("t3_res_cycles", res_cnt,  24);
    check("t3_last_idx",   last_idx, 23);
    check("t3_latency",    cyc + 1,  50);
    step();
    check("t3_idle_ready", seq.ready, 1);

    // Backpressure in DONE
    seq.outReady = 1'b0;
    start_call(2);
    wait_valid(50, cyc);
    check("t4_latency", cyc + 1, 6);
    seq.start     = 1'b1;
    seq.numRounds = RW'(1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_valid", seq.outValid, 1);
      check("t4_hold_ldReg", seq.ldReg,    0);
      check("t4_hold_ready", seq.ready,    0);
    end
    seq.start    = 1'b0;
    seq.outReady = 1'b1;
    step();
    check("t4_idle_ready", seq.ready,    1);
    check("t4_idle_valid", seq.outValid, 0);

    // Async reset in RES of round 1
    start_call(3);
    for (int i = 0; i < 4; i++) step();
    check("t5_pre_selRes", seq.selRes,   1);
    check("t5_pre_idx",    seq.roundIdx, 1);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_ready",  seq.ready,    1);
    check("t5_rst_busy",   seq.busy,     0);
    check("t5_rst_cntEn",  seq.cntEn,    0);
    check("t5_rst_ldReg",  seq.ldReg,    0);
    check("t5_rst_selRes", seq.selRes,   0);
    check("t5_rst_idx",    seq.roundIdx, 0);
    check("t5_rst_valid",  seq.outValid, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    start_call(1);
    wait_valid(50, cyc);
    check("t5_n1_valid",   seq.outValid, 1);
    check("t5_n1_latency", cyc + 1, 4);
    step();
    check("t5_n1_ready", seq.ready, 1);

`ifdef PERM_ABORT_EN
    // Abort in RES of round 2, N=4 (no carry that cycle)
    start_call(4);
    for (int i = 0; i < 6; i++) step();
    check("t6_pre_selRes", seq.selRes,   1);
    check("t6_pre_idx",    seq.roundIdx, 2);
    seq.abort = 1'b1;
    step();
    seq.abort = 1'b0;
    check("t6_abort_ready", seq.ready,    1);
    check("t6_abort_busy",  seq.busy,     0);
    check("t6_abort_idx",   seq.roundIdx, 0);
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      if (seq.outValid) seen_valid = 1;
      step();
    end
    check("t6_no_valid", seen_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
